// File: rtl/branch_predictor_pkg.sv
// Shared encodings and types for the branch target buffer.
package branch_predictor_pkg;

  localparam logic [1:0] CNT_SNT   = 2'b00;
  localparam logic [1:0] CNT_WNT   = 2'b01;
  localparam logic [1:0] CNT_WT    = 2'b10;
  localparam logic [1:0] CNT_ST    = 2'b11;
  localparam logic [1:0] CNT_RESET = CNT_WNT;
  localparam logic [1:0] CNT_ALLOC = CNT_WT;

  localparam int BP_ENTRIES_DEFAULT = 16;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        mispred;
  } bp_upd_t;

endpackage

// File: rtl/bp_sat_cnt.sv
// 2-bit saturating direction counter, next-value only.
module bp_sat_cnt
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken && cur != CNT_ST)        nxt = cur + 2'd1;
    else if (!taken && cur != CNT_SNT) nxt = cur - 2'd1;
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational lookup,
// trained by EX resolutions, plus branch/mispredict performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter  int ENTRIES = BP_ENTRIES_DEFAULT,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [31:0] PC,
  output logic        PreBranch,
  output logic [31:0] PreAddr,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [31:0] br_cnt,
  output logic [31:0] mis_cnt
);

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][31:0]      target_q;
  logic [ENTRIES-1:0][1:0]       cnt_q;
  logic [31:0]                   br_cnt_q, mis_cnt_q;

  bp_upd_t upd;
  assign upd = '{valid: upd_valid, pc: upd_pc, taken: upd_taken,
                 target: upd_target, mispred: upd_mispred};

  // Word-aligned fetch: the low two PC bits carry no information.
  logic unused_lsbs;
  assign unused_lsbs = ^{PC[1:0], upd_pc[1:0]};

  // Lookup reads the registered table only, so same-cycle updates are not bypassed.
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  assign idx = PC[IDX_W+1:2];
  assign tag = PC[31:IDX_W+2];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  assign PreBranch = ce && hit && cnt_q[idx][1];
  assign PreAddr   = (ce && hit) ? target_q[idx] : 32'h0;

  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;
  logic [1:0]       cnt_nxt;
  assign uidx = upd.pc[IDX_W+1:2];
  assign utag = upd.pc[31:IDX_W+2];
  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

  bp_sat_cnt u_sat_cnt (
    .cur   (cnt_q[uidx]),
    .taken (upd.taken),
    .nxt   (cnt_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q   <= {ENTRIES{CNT_RESET}};
    end else if (upd.valid) begin
      if (uhit) begin
        cnt_q[uidx] <= cnt_nxt;
      end else if (upd.taken) begin
        valid_q[uidx] <= 1'b1;
        cnt_q[uidx]   <= CNT_ALLOC;
      end
    end
  end

  // Tag/target carry no reset; a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (upd.valid && upd.taken) begin
      tag_q[uidx]    <= utag;
      target_q[uidx] <= upd.target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (upd.valid) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (upd.mispred) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] PC = 32'h0;
  logic        PreBranch;
  logic [31:0] PreAddr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;
  logic        upd_mispred = 1'b0;
  logic [31:0] br_cnt, mis_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .PC(PC),
    .PreBranch(PreBranch), .PreAddr(PreAddr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  // One update pulse; returns at the following negedge with upd_valid low.
  task automatic do_upd(input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic mp);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispred = mp;
    @(negedge clk);
    upd_valid = 1'b0; upd_mispred = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic exp_br,
                      input logic [31:0] exp_addr, input string name);
    PC = pc; #1;
    n_chk++;
    if (PreBranch !== exp_br) begin
      n_fail++;
      $display("FAIL %s PreBranch got %b want %b", name, PreBranch, exp_br);
    end
    n_chk++;
    if (PreAddr !== exp_addr) begin
      n_fail++;
      $display("FAIL %s PreAddr got %h want %h", name, PreAddr, exp_addr);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    ce = 1'b1; PC = 32'h40;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (PreBranch !== 1'b0 || PreAddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pred got %b/%h want 0/00000000", PreBranch, PreAddr);
    end
    n_chk++;
    if (br_cnt !== 32'h0 || mis_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt got %h/%h want 0/0", br_cnt, mis_cnt);
    end
    #3 rst_n = 1'b1;
    look(32'h40, 1'b0, 32'h0, "post_reset");
  endtask

  task automatic test_allocate;
    do_upd(32'h40, 1'b1, 32'h100, 1'b1);
    look(32'h40, 1'b1, 32'h100, "alloc");
    n_chk++;
    if (br_cnt !== 32'd1 || mis_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL alloc_cnt got %0d/%0d want 1/1", br_cnt, mis_cnt);
    end
    ce = 1'b0;
    look(32'h40, 1'b0, 32'h0, "ce_off");
    ce = 1'b1;
  endtask

  task automatic test_hysteresis;
    do_upd(32'h40, 1'b1, 32'h100, 1'b0);
    do_upd(32'h40, 1'b1, 32'h100, 1'b0);          // 11
    do_upd(32'h40, 1'b0, 32'h0, 1'b0);            // 10
    look(32'h40, 1'b1, 32'h100, "st_to_wt");
    do_upd(32'h40, 1'b0, 32'h0, 1'b0);            // 01
    look(32'h40, 1'b0, 32'h100, "wt_to_wnt");
    for (int i = 0; i < 3; i++) do_upd(32'h40, 1'b0, 32'h0, 1'b0);  // 00
    look(32'h40, 1'b0, 32'h100, "sat_low_valid");
    do_upd(32'h40, 1'b1, 32'h100, 1'b0);          // 01, not wrapped
    look(32'h40, 1'b0, 32'h100, "sat_low_no_wrap");
    do_upd(32'h40, 1'b1, 32'h100, 1'b0);          // 10
    look(32'h40, 1'b1, 32'h100, "back_to_wt");
  endtask

  task automatic test_alias;
    look(32'h80, 1'b0, 32'h0, "alias_miss");
    do_upd(32'h80, 1'b0, 32'h0, 1'b0);
    look(32'h40, 1'b1, 32'h100, "alias_nt_untouched");
    do_upd(32'h80, 1'b1, 32'h200, 1'b1);
    look(32'h40, 1'b0, 32'h0, "alias_evicted");
    look(32'h80, 1'b1, 32'h200, "alias_new");
  endtask

  task automatic test_collision;
    do_upd(32'h40, 1'b1, 32'h100, 1'b0);          // realloc, cnt 10
    @(negedge clk);
    PC = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0; upd_target = 32'h0;
    #1;
    n_chk++;
    if (PreBranch !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_same_cycle got %b want 1", PreBranch);
    end
    @(negedge clk);
    upd_valid = 1'b0;
    look(32'h40, 1'b0, 32'h100, "collide_next");
    n_chk++;
    if (br_cnt !== 32'd14 || mis_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_cnt got %0d/%0d want 14/2", br_cnt, mis_cnt);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    dut.br_cnt_q = 32'hFFFF_FFFF;
    #1;
    do_upd(32'h1000, 1'b0, 32'h0, 1'b0);
    n_chk++;
    if (br_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL br_wrap got %h want 00000000", br_cnt);
    end
    @(negedge clk);
    upd_mispred = 1'b1;
    @(negedge clk);
    upd_mispred = 1'b0;
    #1;
    n_chk++;
    if (mis_cnt !== 32'd2 || br_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL mispred_unqualified got %0d/%0d want 2/0", mis_cnt, br_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_allocate;
    test_hysteresis;
    test_alias;
    test_collision;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
